// File: rtl/bootrom_loader_pkg.sv
// Shared definitions for the boot ROM loader: FSM state encoding and the
// default RAM destination for ROM byte 0.
package bootrom_loader_pkg;

  // Loader FSM states
  localparam logic [1:0] ST_ADDR  = 2'd0;  // present idx to the ROM, wait for data
  localparam logic [1:0] ST_WRITE = 2'd1;  // hold a RAM write until it is accepted
  localparam logic [1:0] ST_DONE  = 2'd2;  // image copied, CPU released

  // RAM address that receives ROM byte 0
  localparam logic [15:0] DEST_BASE_DEFAULT = 16'hF800;

endpackage

// File: rtl/bootrom_loader.sv
// Copies a 2^ADDR_W byte boot image from a synchronous ROM into RAM starting at
// DEST_BASE, holding the CPU in reset until the copy is complete.
//
// RAM handshake: ram_we acts as "valid" and is high only in WRITE. While it is
// high, ram_addr and ram_wdata stay constant. A write is accepted on a rising
// clk edge where ram_we and ram_ready are both high; only then does the loader
// move on to the next byte.
module bootrom_loader
  import bootrom_loader_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter logic [15:0] DEST_BASE = DEST_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [15:0]       ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic              ram_ready,
  input  logic              reload,
  output logic              cpu_reset_n,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;

  // FSM, byte index and the registered done / CPU reset outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_ADDR;
      idx         <= '0;
      done        <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (ram_ready) begin
            if (idx == LAST_IDX) begin
              // Done and CPU release are set on the same edge that enters DONE
              state       <= ST_DONE;
              idx         <= '0;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state <= ST_ADDR;
              idx   <= idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (reload) begin
            state       <= ST_ADDR;
            idx         <= '0;
            done        <= 1'b0;
            cpu_reset_n <= 1'b0;
          end
        end
        default: begin
          state <= ST_ADDR;
          idx   <= '0;
        end
      endcase
    end
  end

  // ROM address and RAM write port; rom_data is stable through a stall
  // because idx (and hence rom_addr) does not change in WRITE until accepted
  always_comb begin
    rom_addr  = idx;
    ram_we    = (state == ST_WRITE);
    ram_addr  = DEST_BASE + 16'(idx);
    ram_wdata = rom_data;
  end

endmodule

// File: tb/tb_bootrom_loader.sv
// Self-checking bench for bootrom_loader: nominal copy timing, random RAM
// stalls, address wrap at the top of memory, reload handling and reset during
// a stalled write.
module tb_bootrom_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: ADDR_W=4, default base F800
  logic        reset_n = 1'b0;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_ready = 1'b1;
  logic        reload = 1'b0;
  logic        cpu_reset_n;
  logic        done;

  // instance b: ADDR_W=4, base FFF8 (wrap test)
  logic        reset_n_b = 1'b0;
  logic [3:0]  rom_addr_b;
  logic [7:0]  rom_data_b = 8'h00;
  logic [15:0] ram_addr_b;
  logic [7:0]  ram_wdata_b;
  logic        ram_we_b;
  logic        ram_ready_b = 1'b1;
  logic        reload_b = 1'b0;
  logic        cpu_reset_n_b;
  logic        done_b;

  bootrom_loader #(.ADDR_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_ready(ram_ready), .reload(reload), .cpu_reset_n(cpu_reset_n), .done(done)
  );

  bootrom_loader #(.ADDR_W(4), .DEST_BASE(16'hFFF8)) u_dut_b (
    .clk(clk), .reset_n(reset_n_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b),
    .ram_ready(ram_ready_b), .reload(reload_b), .cpu_reset_n(cpu_reset_n_b),
    .done(done_b)
  );

  // ---------------- ROM models (one cycle read latency) ----------------
  logic [7:0] rom   [16];
  logic [7:0] rom_b [16];
  always @(posedge clk) rom_data   <= rom[rom_addr];
  always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];          // {ram_addr, ram_wdata} in expected order
  logic [7:0]  ram_img [16];
  int          wr_cnt = 0;
  logic        mon_en = 1'b0;
  int          ready_mode = 0;    // 0: always ready, 1: random stalls, 2: stall at F807
  int          stall_left = 0;
  logic        in_stall = 1'b0;
  logic [15:0] stall_addr;
  logic [7:0]  stall_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Load the expected write stream for one full copy from the current ROM
  task automatic start_copy();
    exp_q.delete();
    wr_cnt   = 0;
    in_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ram_img[i] = 8'hxx;
      exp_q.push_back({16'hF800 + 16'(i), rom[i]});
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_copy(input string tag);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd16);
    check({tag, "_q_left"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 16; i++)
      check({tag, "_img"}, 32'(ram_img[i]), 32'(rom[i]));
  endtask

  // Ready driver and write monitor for instance a. ram_ready is chosen for
  // the coming rising edge, then the write that edge will accept is scored.
  always @(negedge clk) begin
    case (ready_mode)
      1: begin
        if (ram_we && stall_left > 0) begin
          ram_ready = 1'b0;
          stall_left--;
        end else begin
          ram_ready = 1'b1;
          if (ram_we) stall_left = $urandom_range(0, 5);
        end
      end
      2: ram_ready = !(ram_we && ram_addr == 16'hF807);
      default: ram_ready = 1'b1;
    endcase
    if (mon_en) begin
      if (in_stall && ram_we) begin
        check("stall_addr", 32'(ram_addr), 32'(stall_addr));
        check("stall_data", 32'(ram_wdata), 32'(stall_data));
      end
      in_stall   = ram_we && !ram_ready;
      stall_addr = ram_addr;
      stall_data = ram_wdata;
      if (ram_we && ram_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_write", 32'(ram_addr), 32'hFFFFFFFF);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(e[23:8]));
          check("wr_data", 32'(ram_wdata), 32'(e[7:0]));
        end
        ram_img[ram_addr[3:0]] = ram_wdata;
        wr_cnt++;
      end
    end
  end

  // ---------------- main sequence ----------------
  logic [7:0] snap [16];
  int done_cycle;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 16; i++) rom_b[i] = 8'($urandom);

    // Test 1: nominal copy, ready tied high
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cpu", 32'(cpu_reset_n), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    start_copy();
    mon_en  = 1'b1;
    reset_n = 1'b1;
    done_cycle = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 && done_cycle == 0) done_cycle = k + 1;
      if (k == 31 || k == 32 || k == 33) check("cpu_with_done", 32'(cpu_reset_n), 32'(done));
    end
    check("done_cycle", 32'(done_cycle), 32'd33);
    check_copy("t1");

    // Test 2: random ready stalls of 0-5 cycles
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    ready_mode = 1;
    stall_left = $urandom_range(0, 5);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    start_copy();
    reset_n = 1'b1;
    wait_done(300);
    check_copy("t2");

    // Test 3: reload during copy ignored, then reload from DONE
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    reset_n = 1'b0;
    @(negedge clk);
    start_copy();
    reset_n = 1'b1;
    repeat (7) @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    wait_done(300);
    repeat (4) @(negedge clk);
    check("done_hold", 32'(done), 32'd1);
    check_copy("t3a");
    for (int i = 0; i < 16; i++) snap[i] = ram_img[i];
    start_copy();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_done", 32'(done), 32'd0);
    check("reload_cpu", 32'(cpu_reset_n), 32'd0);
    wait_done(300);
    check_copy("t3b");
    for (int i = 0; i < 16; i++) check("t3_same", 32'(ram_img[i]), 32'(snap[i]));

    // Test 4: reset while the write of idx 7 is stalled
    ready_mode = 2;
    reset_n = 1'b0;
    @(negedge clk);
    start_copy();
    reset_n = 1'b1;
    begin
      int n;
      n = 0;
      while (!(ram_we === 1'b1 && ram_addr === 16'hF807) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("stall7_reached", 32'(ram_addr), 32'hF807);
    end
    repeat (2) @(negedge clk);
    check("stall7_we", 32'(ram_we), 32'd1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_stall_we", 32'(ram_we), 32'd0);
    check("rst_stall_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_stall_cpu", 32'(cpu_reset_n), 32'd0);
    ready_mode = 0;
    start_copy();
    mon_en  = 1'b1;
    reset_n = 1'b1;
    check("restart_addr_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    check("restart_we", 32'(ram_we), 32'd1);
    check("restart_rom_addr", 32'(rom_addr), 32'd0);
    wait_done(300);
    check_copy("t4");

    // Test 5: destination wraps past FFFF on instance b
    begin
      int n;
      logic [15:0] ea;
      n = 0;
      @(negedge clk);
      reset_n_b = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (ram_we_b) begin
          ea = 16'hFFF8 + 16'(n);
          check("wrap_addr", 32'(ram_addr_b), 32'(ea));
          check("wrap_data", 32'(ram_wdata_b), 32'(rom_b[n % 16]));
          n++;
        end
      end
      check("wrap_writes", 32'(n), 32'd16);
      check("wrap_done", 32'(done_b), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bootrom_loader.md
BOOTROM_LOADER -- requirements
Module: bootrom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning boot ROM address width (image size 2^ADDR_W bytes).
REQ-002 SHALL have parameter DEST_BASE, default 16'hF800, meaning the 16-bit RAM address that receives ROM byte 0.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rom_addr  output  ADDR_W  read address to the boot ROM.
REQ-006 SHALL have port rom_data  input  8  boot ROM read data, valid one clk after rom_addr is sampled.
REQ-007 SHALL have port ram_addr  output  16  RAM write address.
REQ-008 SHALL have port ram_wdata  output  8  RAM write data.
REQ-009 SHALL have port ram_we  output  1  RAM write request.
REQ-010 SHALL have port ram_ready  input  1  RAM accepts the write on a cycle where ram_we and ram_ready are both high.
REQ-011 SHALL have port reload  input  1  single-cycle request to repeat the copy.
REQ-012 SHALL have port cpu_reset_n  output  1  CPU reset; low while copying.
REQ-013 SHALL have port done  output  1  high once the whole image is in RAM.

Function
REQ-014 SHALL implement states ADDR, WRITE and DONE, with a byte index idx of ADDR_W bits.
REQ-015 SHALL drive rom_addr = idx in every state.
REQ-016 SHALL, in ADDR: keep ram_we=0 and go to WRITE on the next clk.
REQ-017 SHALL, in WRITE: drive ram_we=1, ram_addr=(DEST_BASE+idx) mod 2^16 and ram_wdata=rom_data.
REQ-018 SHALL stay in WRITE with idx, ram_addr and ram_wdata unchanged while ram_ready=0 (stall of any length).
REQ-019 SHALL, on an accepted write with idx < 2^ADDR_W-1: increment idx and go to ADDR.
REQ-020 SHALL, on an accepted write with idx = 2^ADDR_W-1: go to DONE with idx wrapping to 0.
REQ-021 SHALL keep ram_we=0 in ADDR and DONE.
REQ-022 SHALL give a minimum copy time of 2*2^ADDR_W cycles with ram_ready tied high.
REQ-023 SHALL, in DONE: set done=1 and cpu_reset_n=1, both registered, first high the cycle after entering DONE.
REQ-024 SHALL, on reload=1 in DONE: go to ADDR with idx=0, and set done=0 and cpu_reset_n=0 on the same edge.
REQ-025 SHALL ignore reload in ADDR and WRITE.
REQ-026 SHALL issue exactly one accepted write per address; no address is skipped or duplicated.

Reset
REQ-027 SHALL, on clk with reset_n=0: set state=ADDR, idx=0, done=0 and cpu_reset_n=0, with ram_we=0 from that edge.
REQ-028 SHALL let reset override every other input, including mid-copy and during a WRITE stall.
REQ-029 SHALL, after reset mid-copy, restart from idx=0, and the first cycle after reset_n rises SHALL be ADDR.

Structure
REQ-030 SHALL place the state encoding (ADDR, WRITE, DONE) and the default DEST_BASE in the shared project package.
REQ-031 SHALL have no sub-module; the boot ROM is instantiated alongside it by the parent and connected through rom_addr and rom_data.

Verification
REQ-032 SHALL test, with ADDR_W=4, ROM[i]=i^8'hA5 and ram_ready=1: writes to F800..F80F carry those values, done rises in cycle 33 after reset release, and cpu_reset_n rises with done.
REQ-033 SHALL test random ram_ready stalls of 0-5 cycles: exactly 16 accepted writes, ram_addr and ram_wdata stable through each stall, and the RAM image matches the ROM.
REQ-034 SHALL test DEST_BASE=16'hFFF8 with ADDR_W=4: addresses wrap FFF8..FFFF then 0000..0007.
REQ-035 SHALL test a reload pulse during copy (ignored, one copy only) followed by reload in DONE: done and cpu_reset_n drop next edge and a full second copy is identical.
REQ-036 SHALL test reset_n=0 at idx=7 during a stall: ram_we drops next edge, and after release the copy restarts at rom_addr=0 and completes.
